// File: rtl/ulpi_reg_pkg.sv
// Shared types and widths for the ULPI register-access arbiter.
package ulpi_reg_pkg;

  localparam int ULPI_REG_ADDR_W = 6;
  localparam int ULPI_REG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ulpi_reg_state_e;

endpackage

// File: rtl/ulpi_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module ulpi_rr_arb #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    jj        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDX_W'(j);
      if (req[jj]) begin
        grant     = NREQ'(1) << jj;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Arbitrates NREQ requesters onto one ULPI link register port, one access at a time.
// Define ULPI_REG_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles (rsp_err on expiry).
module ulpi_reg_arbiter
  import ulpi_reg_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  // Handshake: a requester holds req_valid and its payload until it sees its
  // req_ready bit; ready is a one-cycle accept, and the matching rsp_valid bit
  // later pulses for one cycle carrying rsp_rdata/rsp_err.
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*ULPI_REG_ADDR_W-1:0]     req_addr,
  input  logic [NREQ*ULPI_REG_DATA_W-1:0]     req_wdata,
  input  logic [NREQ-1:0]                     req_rnw,
  output logic [NREQ-1:0]                     rsp_valid,
  output logic [ULPI_REG_DATA_W-1:0]          rsp_rdata,
  output logic                                rsp_err,
  output logic [ULPI_REG_ADDR_W-1:0]          reg_addr,
  output logic [ULPI_REG_DATA_W-1:0]          reg_data_write,
  output logic                                reg_read_nwrite,
  output logic                                reg_enable,
  input  logic                                reg_done,
  input  logic [ULPI_REG_DATA_W-1:0]          reg_data_read,
  output ulpi_reg_state_e                     dbg_state
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("ulpi_reg_arbiter: NREQ must be 2..4 and TIMEOUT 2..255");
  end

  ulpi_reg_state_e            state, state_nxt;
  logic [IDX_W-1:0]           rr_ptr, cur_idx, arb_idx;
  logic [NREQ-1:0]            arb_grant;
  logic                       grant_fire, wait_exit, wait_timeout;
  logic [ULPI_REG_ADDR_W-1:0] sel_addr;
  logic [ULPI_REG_DATA_W-1:0] sel_wdata;
  logic                       sel_rnw;

  ulpi_rr_arb #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rnw   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ULPI_REG_ADDR_W +: ULPI_REG_ADDR_W];
        sel_wdata = req_wdata[i*ULPI_REG_DATA_W +: ULPI_REG_DATA_W];
        sel_rnw   = req_rnw[i];
      end
    end
  end

  assign grant_fire = (state == IDLE) && (|req_valid);
  assign wait_exit  = (state == WAIT) && (reg_done || wait_timeout);
  assign dbg_state  = state;

`ifdef ULPI_REG_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 8'd1;
  end

  assign wait_timeout = (state == WAIT) && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       rsp_err <= 1'b0;
    else if (wait_exit) rsp_err <= !reg_done;
  end
`else
  assign wait_timeout = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    rsp_valid  = '0;
    reg_enable = 1'b0;
    case (state)
      IDLE: if (grant_fire) begin
        req_ready = arb_grant;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        reg_enable = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: if (wait_exit) state_nxt = RESP;
      RESP: begin
        rsp_valid = NREQ'(1) << cur_idx;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cur_idx         <= '0;
      reg_addr        <= '0;
      reg_data_write  <= '0;
      reg_read_nwrite <= 1'b0;
      rsp_rdata       <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        cur_idx         <= arb_idx;
        rr_ptr          <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        reg_addr        <= sel_addr;
        reg_data_write  <= sel_wdata;
        reg_read_nwrite <= sel_rnw;
      end
      // Writes and timeouts report zero data.
      if (wait_exit) rsp_rdata <= (reg_done && reg_read_nwrite) ? reg_data_read : '0;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter; timeout cases run when ULPI_REG_TIMEOUT_EN is defined.
module tb_ulpi_reg_arbiter;
  import ulpi_reg_pkg::*;

  localparam int NREQ  = 2;
  localparam int TMO   = 8;
  localparam int RSP_W = NREQ + 9;
`ifdef ULPI_REG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_rnw, rsp_valid;
  logic [NREQ*6-1:0]    req_addr;
  logic [NREQ*8-1:0]    req_wdata;
  logic [7:0]           rsp_rdata, reg_data_write, reg_data_read;
  logic                 rsp_err, reg_read_nwrite, reg_enable, reg_done;
  logic [5:0]           reg_addr;
  ulpi_reg_state_e      dbg_state;

  ulpi_reg_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rnw(req_rnw),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_addr(reg_addr), .reg_data_write(reg_data_write),
    .reg_read_nwrite(reg_read_nwrite), .reg_enable(reg_enable),
    .reg_done(reg_done), .reg_data_read(reg_data_read),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state: pending requesters and their payloads
  int              checks = 0;
  int              errors = 0;
  logic [NREQ-1:0] pend;
  logic [5:0]      m_addr  [NREQ];
  logic [7:0]      m_wdata [NREQ];
  logic            m_rnw   [NREQ];
  int              last_grant = -1;
  logic [7:0]      last_rdata;
  logic            last_err;
  logic [RSP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend[i];
      req_addr[i*6 +: 6]   = m_addr[i];
      req_wdata[i*8 +: 8]  = m_wdata[i];
      req_rnw[i]           = m_rnw[i];
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [7:0] w, input logic rnw);
    pend[i]    = 1'b1;
    m_addr[i]  = a;
    m_wdata[i] = w;
    m_rnw[i]   = rnw;
  endtask

  // Round robin: first pending requester after the last one served.
  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(last_grant + 1 + k) % NREQ]) return (last_grant + 1 + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++)
      if (v[i]) r = (r == -1) ? i : 99;
    return r;
  endfunction

  // One full transaction starting in an IDLE cycle. d = cycles from reg_enable
  // to reg_done (0 = never). obs = requester index the DUT actually granted.
  task automatic run_txn(input int d, input logic [7:0] rd, input bit spur, output int obs);
    int g, nw;
    bit done;
    logic [7:0] er, ew;
    logic [5:0] ea;
    logic ernw;
    logic [RSP_W-1:0] e;
    if (!TO_EN && d < 1) d = 1;
    drive_req();
    reg_done = 1'b0;
    #1;
    check("idle_rsp_valid", rsp_valid, 0);
    check("hold_rdata", rsp_rdata, last_rdata);
    check("hold_err", rsp_err, last_err);
    check("idle_enable", reg_enable, 0);
    g   = model_pick();
    obs = onehot_idx(req_ready);
    if (g < 0) begin
      check("ready_none", req_ready, 0);
      return;
    end
    check("req_ready", req_ready, 32'(1) << g);
    ea = m_addr[g]; ew = m_wdata[g]; ernw = m_rnw[g];
    last_grant = g;
    nw = d; done = 1'b1;
    if (TO_EN && (d == 0 || d > TMO)) begin nw = TMO; done = 1'b0; end
    er = (done && ernw) ? rd : 8'h00;
    exp_q.push_back({NREQ'(1 << g), er, !done});

    step();
    pend[g] = 1'b0;
    drive_req();
    reg_done      = spur;
    reg_data_read = 8'($urandom);
    #1;
    check("issue_enable", reg_enable, 1);
    check("issue_addr", reg_addr, ea);
    check("issue_wdata", reg_data_write, ew);
    check("issue_rnw", reg_read_nwrite, ernw);
    check("issue_ready", req_ready, 0);
    check("issue_rsp_valid", rsp_valid, 0);

    for (int k = 1; k <= nw; k++) begin
      step();
      reg_done      = done && (k == nw);
      reg_data_read = (k == nw) ? rd : 8'($urandom);
      #1;
      check("wait_enable", reg_enable, 0);
      check("wait_rsp_valid", rsp_valid, 0);
      check("wait_addr", reg_addr, ea);
    end

    step();
    reg_done = 1'b0;
    #1;
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, e[RSP_W-1:9]);
    check("rsp_rdata", rsp_rdata, e[8:1]);
    check("rsp_err", rsp_err, e[0]);
    check("resp_ready", req_ready, 0);
    check("resp_addr", reg_addr, ea);
    last_rdata = e[8:1];
    last_err   = e[0];
    step();
  endtask

  initial begin
    int obs;
    reset_n = 1'b0;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_rnw = '0;
    reg_done = 1'b0; reg_data_read = '0;
    pend = '0; last_rdata = '0; last_err = 1'b0;
    for (int i = 0; i < NREQ; i++) begin m_addr[i] = '0; m_wdata[i] = '0; m_rnw[i] = 1'b0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_data_write, 0);
    check("rst_enable", reg_enable, 0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    step();

    // Single write from requester 0
    set_req(0, 6'h04, 8'h55, 1'b0);
    run_txn(3, 8'h3C, 1'b0, obs);
    check("write_grant", obs, 0);

    // Single read from requester 1
    set_req(1, 6'h16, 8'h00, 1'b1);
    run_txn(2, 8'hA7, 1'b0, obs);
    check("read_grant", obs, 1);

    // Contention: both valid continuously, expected order 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) set_req(i, 6'($urandom), 8'($urandom), 1'($urandom));
      run_txn($urandom_range(1, 4), 8'($urandom), 1'b0, obs);
      check("rr_order", obs, t % 2);
    end
    pend = '0;

    // Spurious reg_done in IDLE, then in ISSUE
    drive_req();
    reg_done = 1'b1;
    reg_data_read = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      step();
      check("spur_idle_rsp", rsp_valid, 0);
      check("spur_idle_state", dbg_state, IDLE);
    end
    reg_done = 1'b0;
    step();
    set_req(0, 6'h2A, 8'h00, 1'b1);
    run_txn(3, 8'h81, 1'b1, obs);
    check("spur_issue_grant", obs, 1 - 1);

    // WAIT bound: timeout, done on the limit cycle, then a normal access
    if (TO_EN) begin
      set_req(1, 6'h0A, 8'h00, 1'b1);
      run_txn(0, 8'hFF, 1'b0, obs);
      set_req(0, 6'h0B, 8'h00, 1'b1);
      run_txn(TMO, 8'h5A, 1'b0, obs);
      set_req(1, 6'h0C, 8'h00, 1'b1);
      run_txn(2, 8'hC3, 1'b0, obs);
      check("after_to_grant", obs, 1);
    end else begin
      set_req(1, 6'h0A, 8'h00, 1'b1);
      run_txn(20, 8'h77, 1'b0, obs);
    end

    // Reset while in WAIT
    set_req(1, 6'h33, 8'h12, 1'b0);
    set_req(0, 6'h34, 8'h13, 1'b0);
    drive_req();
    step();
    pend = '0;
    drive_req();
    step();
    reset_n = 1'b0;
    #1;
    check("rstw_state", dbg_state, IDLE);
    check("rstw_enable", reg_enable, 0);
    check("rstw_addr", reg_addr, 0);
    check("rstw_wdata", reg_data_write, 0);
    check("rstw_rnw", reg_read_nwrite, 0);
    check("rstw_rdata", rsp_rdata, 0);
    check("rstw_err", rsp_err, 0);
    reg_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("rstw_rsp_valid", rsp_valid, 0);
    end
    reg_done = 1'b0;
    reset_n = 1'b1;
    last_grant = -1; last_rdata = '0; last_err = 1'b0;
    exp_q.delete();
    set_req(0, 6'h01, 8'h02, 1'b0);
    set_req(1, 6'h03, 8'h04, 1'b1);
    run_txn(2, 8'h99, 1'b0, obs);
    check("post_rst_grant", obs, 0);

    // Random traffic, including requesters withdrawing before being served
    for (int t = 0; t < 40; t++) begin
      int d;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, 6'($urandom), 8'($urandom), 1'($urandom));
        else if (pend[i] && $urandom_range(0, 3) == 0)
          pend[i] = 1'b0;
      end
      if (pend == '0) set_req($urandom_range(0, NREQ - 1), 6'($urandom), 8'($urandom), 1'($urandom));
      d = (TO_EN && $urandom_range(0, 4) == 0) ? $urandom_range(7, 12) : $urandom_range(1, 6);
      run_txn(d, 8'($urandom_range(1, 255)), 1'($urandom), obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_arbiter.md
ULPI_REG_ARBITER -- requirements
Module: ulpi_reg_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, number of register-access requesters (legal 2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, WAIT-state cycle limit (legal 2..255).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester access request, held until req_ready.
REQ-006 req_ready  out  NREQ  one-hot grant/accept pulse.
REQ-007 req_addr  in  NREQ*6  per-requester ULPI register address, slice i = [6i+5:6i].
REQ-008 req_wdata  in  NREQ*8  per-requester write data, slice i = [8i+7:8i].
REQ-009 req_rnw  in  NREQ  per-requester 1=read, 0=write.
REQ-010 rsp_valid  out  NREQ  one-hot completion pulse to granted requester.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-012 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-013 reg_addr  out  6, reg_data_write  out  8, reg_read_nwrite  out  1, reg_enable  out  1: link register command port.
REQ-014 reg_done  in  1, reg_data_read  in  8: link register completion port.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-016 IDLE with any req_valid: select one requester round-robin, assert its req_ready that same cycle (combinational), latch addr/wdata/rnw/index, go ISSUE.
REQ-017 Round-robin: search starts at last granted index + 1 modulo NREQ; after reset search starts at 0.
REQ-018 ISSUE: reg_enable=1 for exactly one cycle with latched command on reg_addr/reg_data_write/reg_read_nwrite; go WAIT.
REQ-019 reg_addr/reg_data_write/reg_read_nwrite SHALL hold latched values from ISSUE through RESP.
REQ-020 WAIT: on reg_done=1 capture reg_data_read (reads; writes capture 0), rsp_err=0, go RESP.
REQ-021 reg_done SHALL be ignored in IDLE, ISSUE, RESP.
REQ-022 RESP: rsp_valid[index]=1 for one cycle with rsp_rdata/rsp_err; go IDLE; next grant earliest the following cycle.
REQ-023 Latency: grant cycle to reg_enable = 1 cycle; reg_done to rsp_valid = 1 cycle.
REQ-024 req_valid deassert before req_ready SHALL be legal; the requester simply loses its turn.
REQ-025 rsp_rdata/rsp_err SHALL hold last response value outside RESP.

Reset
REQ-026 On reset_n=0 (any state, including mid-transaction): state IDLE, rr pointer 0, all outputs 0, timeout counter 0; an in-flight link access is abandoned without response.

Configuration
REQ-027 Macro ULPI_REG_TIMEOUT_EN defined: WAIT counter increments per cycle; reaching TIMEOUT without reg_done goes RESP with rsp_err=1, rsp_rdata=0; reg_done in the same cycle as the limit wins (rsp_err=0).
REQ-028 Macro undefined: no counter, WAIT lasts until reg_done, rsp_err tied 0.

Structure
REQ-029 Package ulpi_reg_pkg SHALL hold the state enum, ULPI_REG_ADDR_W=6, ULPI_REG_DATA_W=8.
REQ-030 Round-robin selection SHALL be sub-module ulpi_rr_arb (NREQ, req vector, pointer -> one-hot grant).

Verification
REQ-031 Single write: req 0 addr 0x04 wdata 0x55, reg_done 3 cycles after reg_enable -> one reg_enable pulse with 0x04/0x55/rnw 0, rsp_valid=01 next cycle, rsp_err 0.
REQ-032 Single read: req 1 addr 0x16, reg_data_read 0xA7 with reg_done -> rsp_valid=10, rsp_rdata 0xA7.
REQ-033 Contention: req 0 and 1 valid continuously, 4 transactions -> grant order 0,1,0,1.
REQ-034 Timeout (macro defined, TIMEOUT 8): reg_done never asserted -> rsp_valid 8 cycles after WAIT entry, rsp_err 1, rsp_rdata 0; next request proceeds normally.
REQ-035 Reset in WAIT: reset_n low 2 cycles -> all outputs 0, no rsp_valid, next request granted to index 0 first.
REQ-036 Spurious reg_done in IDLE and ISSUE -> no rsp_valid, transaction completes only on WAIT reg_done.
